regfile16_rd_stage: RTL
=======================

// Module: regfile16_rd_stage
// PURPOSE
// - 16-entry x WIDTH register file with one write port and two registered read ports.
// - Sits at the decode/execute boundary. It holds the 16 architectural registers and presents
//   the selected operands to execute one cycle after the read addresses arrive.
// - Includes same-cycle write-to-read bypass, a hard-wired zero register, and pipeline stall/flush.
// PARAMETERS
// - WIDTH     64  data width of each register and of each read/write port
// - ZERO_REG  15  register index that always reads 0 and ignores writes
// PORTS
// - clk        in   1      rising-edge clock
// - reset_n    in   1      asynchronous, active-low reset
// - wr_en      in   1      write enable (writeback stage)
// - wr_addr    in   4      write register index
// - wr_data    in   WIDTH  write data
// - rd_addr_a  in   4      read port A register index (decode stage)
// - rd_addr_b  in   4      read port B register index
// - stall      in   1      hold the read stage; re-read the held addresses
// - flush      in   1      insert a bubble: read outputs go to 0
// - rd_data_a  out  WIDTH  registered operand A
// - rd_data_b  out  WIDTH  registered operand B
// BEHAVIOUR
// - Reset (reset_n=0, async):
//   - all 16 registers, rd_data_a/b and the held read addresses clear to 0 immediately.
//   - Takes effect mid-write or mid-stall. Nothing from before reset is retained.
// - Write: at posedge, if wr_en && wr_addr!=ZERO_REG then regs[wr_addr] <= wr_data.
//   - A write to ZERO_REG is silently dropped.
// - Effective read address per port:
//   - eff_addr = stall ? held_addr : rd_addr.
//   - held_addr <= eff_addr at every posedge, so it stays frozen while stall=1.
// - Read value per port:
//   - 0 if eff_addr==ZERO_REG;
//   - else wr_data if wr_en && wr_addr==eff_addr (bypass);
//   - else regs[eff_addr].
// - Output register per port, at posedge:
//   - flush=1 -> rd_data <= 0. Flush has priority over stall.
//   - else rd_data <= read value. This applies during stall too, so a writeback landing
//     during a stall is seen.
// - Latency:
//   - address at edge N -> data valid after edge N+1.
//   - write at edge N is visible on rd_data after edge N+1 via bypass, with no extra bubble.
// - Both ports may read the same index, and either may match wr_addr. Each port resolves independently.
// - Address widths are exact (16 entries). There are no out-of-range indices and no wrap handling.
// - Arithmetic: none. Data passes bit-exact with no sign/zero extension.
// STRUCTURE
// - Package regfile_pkg:
//   - localparam NREGS=16, ADDR_W=4, ZERO_REG=15;
//   - typedef logic [ADDR_W-1:0] reg_idx_t.
// - Sub-module regfile_read_port (one instance per port):
//   - holds held_addr, the per-bit 16:1 select, the bypass compare and the output register
//     with flush/stall.
// - Top level: register array, write decode, two regfile_read_port instances.
// TESTING
// - Reset: load all regs, pulse reset_n low between edges -> outputs 0 immediately;
//   reading R0..R14 afterwards returns 0.
// - Write/read: write R3=64'hDEAD_BEEF_0123_4567; next cycle read A=3 -> value
//   appears after the following edge; B=4 -> 0.
// - Bypass: wr_en, wr_addr=7, wr_data=64'h55 with rd_addr_a=rd_addr_b=7 in the
//   same cycle -> both outputs 64'h55 after that edge.
// - Zero reg: write R15=64'hFFFF_FFFF_FFFF_FFFF, read A=15 (with and without
//   same-cycle write) -> always 0.
// - Stall: read A=2 (R2=10), assert stall 3 cycles while rd_addr_a changes to 9
//   and R2 is written to 20 -> rd_data_a shows 10, then 20. It never shows R9.
//   After stall drops, R9 appears one cycle later.
// - Flush: flush=1 together with stall=1 while reading R5=99 -> outputs 0 next
//   cycle. Flush then drops with stall held -> outputs show R5 (99) again.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing and index type for the 16-entry register file and its read ports.
package regfile_pkg;
    localparam int NREGS    = 16;
    localparam int ADDR_W   = 4;
    localparam int ZERO_REG = 15;

    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: held address for stall, zero-register and write bypass
// resolution, and the output register with flush.
module regfile_read_port #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [WIDTH-1:0]                   regs_i [regfile_pkg::NREGS],
    input  logic                               wr_en_i,
    input  logic [regfile_pkg::ADDR_W-1:0]     wr_addr_i,
    input  logic [WIDTH-1:0]                   wr_data_i,
    input  logic [regfile_pkg::ADDR_W-1:0]     rd_addr_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    output logic [WIDTH-1:0]                   rd_data_o
);
    import regfile_pkg::*;

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    reg_idx_t         held_q;
    reg_idx_t         eff_addr;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // While stalled the port keeps re-reading the address it captured last cycle.
    assign eff_addr = stall_i ? held_q : rd_addr_i;

    always_comb begin
        rd_val = regs_i[eff_addr];
        if (eff_addr == ZERO_IDX) begin
            rd_val = '0;
        end else if (wr_en_i && (wr_addr_i == eff_addr)) begin
            rd_val = wr_data_i;
        end
        rd_data_d = flush_i ? '0 : rd_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q    <= '0;
            rd_data_q <= '0;
        end else begin
            held_q    <= eff_addr;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/regfile16_rd_stage.sv
// Decode/execute boundary register file: 16 architectural registers, one write port,
// two independent registered read ports with bypass, stall and flush.
module regfile16_rd_stage #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [regfile_pkg::ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic [regfile_pkg::ADDR_W-1:0] rd_addr_a,
    input  logic [regfile_pkg::ADDR_W-1:0] rd_addr_b,
    input  logic                           stall,
    input  logic                           flush,
    output logic [WIDTH-1:0]               rd_data_a,
    output logic [WIDTH-1:0]               rd_data_b
);
    import regfile_pkg::*;

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    logic [WIDTH-1:0] regs_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam reg_idx_t IDX = reg_idx_t'(gi);
            logic wr_hit;

            // Writes aimed at the zero register never land, so it stays cleared.
            assign wr_hit = wr_en && (wr_addr == IDX) && (wr_addr != ZERO_IDX);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    regs_q[gi] <= '0;
                end else if (wr_hit) begin
                    regs_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .regs_i    (regs_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_a),
        .stall_i   (stall),
        .flush_i   (flush),
        .rd_data_o (rd_data_a)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .regs_i    (regs_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_b),
        .stall_i   (stall),
        .flush_i   (flush),
        .rd_data_o (rd_data_b)
    );
endmodule
